// File: rtl/uart_pkg.sv
// Shared constants and types for the UART transmit queue.
package uart_pkg;

  localparam int UART_WORD_WIDTH = 9;
  localparam int QUEUE_DEPTH     = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    SEND = 2'd2,
    WAIT = 2'd3
  } issue_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Circular FIFO with registered occupancy count and a sticky overflow flag.
module sync_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = QUEUE_DEPTH,
  parameter int WIDTH = UART_WORD_WIDTH
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  input  logic                     clr_overflow,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count_q;
  logic             push_ok;
  logic             pop_ok;

  // Full/empty come from the registered count, so a pop in the same cycle
  // never makes room for a push that arrives while full.
  assign full     = (count_q == CNT_W'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign push_ok  = push && !full;
  assign pop_ok   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count_q  <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      // A dropped push outranks a clear in the same cycle.
      if (push && full)      overflow <= 1'b1;
      else if (clr_overflow) overflow <= 1'b0;
    end
  end

  // Storage carries no reset; validity is defined by the pointers and count.
  always_ff @(posedge clock) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/uart_tx_queue.sv
// Transmit queue: buffers words and issues them one at a time to the UART
// transmitter over its send/data/ready handshake.
module uart_tx_queue
  import uart_pkg::*;
#(
  parameter int DEPTH = QUEUE_DEPTH,
  parameter int WIDTH = UART_WORD_WIDTH
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     clr_overflow,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  input  logic                     tx_ready,
  output logic                     tx_send,
  output logic [WIDTH-1:0]         tx_data
);

  issue_state_t     state_q;
  issue_state_t     state_d;
  logic             issue;
  logic [WIDTH-1:0] head_data;

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH)
  ) u_fifo (
    .clock        (clock),
    .reset        (reset),
    .push         (wr_en),
    .push_data    (wr_data),
    .pop          (issue),
    .pop_data     (head_data),
    .clr_overflow (clr_overflow),
    .full         (full),
    .empty        (empty),
    .count        (count),
    .overflow     (overflow)
  );

  // Ready must be seen on two consecutive cycles (IDLE then ARM) so the
  // one-cycle ready blip at the transmitter's final stop-bit tick is ignored.
  always_comb begin
    state_d = state_q;
    issue   = 1'b0;
    case (state_q)
      IDLE: if (!empty && tx_ready) state_d = ARM;
      ARM: begin
        if (tx_ready && !empty) begin
          state_d = SEND;
          issue   = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      SEND: state_d = WAIT;
      WAIT: if (!tx_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      tx_send <= 1'b0;
      tx_data <= '0;
    end else begin
      state_q <= state_d;
      tx_send <= issue;
      if (issue) tx_data <= head_data;
    end
  end

endmodule

// File: tb/tb_uart_tx_queue.sv
// Directed self-checking bench for uart_tx_queue with a simple transmitter model.
module tb_uart_tx_queue;
  import uart_pkg::*;

  localparam int DEPTH = 8;
  localparam int WIDTH = 9;

  logic             clock = 1'b0;
  logic             reset;
  logic             wr_en;
  logic [WIDTH-1:0] wr_data;
  logic             clr_overflow;
  logic             full;
  logic             empty;
  logic [3:0]       count;
  logic             overflow;
  logic             tx_ready;
  logic             tx_send;
  logic [WIDTH-1:0] tx_data;

  int n_checks = 0;
  int n_errors = 0;

  logic [WIDTH-1:0] pvec [32];
  logic [WIDTH-1:0] evec [32];

  uart_tx_queue #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clock        (clock),
    .reset        (reset),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .clr_overflow (clr_overflow),
    .full         (full),
    .empty        (empty),
    .count        (count),
    .overflow     (overflow),
    .tx_ready     (tx_ready),
    .tx_send      (tx_send),
    .tx_data      (tx_data)
  );

  always #20 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset        = 1'b1;
    wr_en        = 1'b0;
    wr_data      = '0;
    clr_overflow = 1'b0;
    tx_ready     = 1'b0;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic push_word(input logic [WIDTH-1:0] d);
    wr_en   = 1'b1;
    wr_data = d;
    step();
    wr_en   = 1'b0;
  endtask

  // Transmitter model: ready drops when tx_send is seen and returns after
  // busy_len cycles. Pushes pvec[0..n_push-1] whenever not full, expects
  // evec[0..n_exp-1] on tx_data in order.
  task automatic run_model(input int n_push, input int n_exp, input int busy_len,
                           input int max_cycles);
    int   idx   = 0;
    int   rx    = 0;
    int   busy  = 0;
    logic hist1 = 1'b0;
    logic hist2 = 1'b0;
    logic r_now;
    for (int cyc = 0; cyc < max_cycles && !(rx == n_exp && idx == n_push); cyc++) begin
      r_now = tx_ready;
      if (idx < n_push && !full) begin
        wr_en   = 1'b1;
        wr_data = pvec[idx];
        idx++;
      end else begin
        wr_en = 1'b0;
      end
      step();
      hist2 = hist1;
      hist1 = r_now;
      if (tx_send) begin
        check("ready_two_cycles", 32'({hist2, hist1}), 32'd3);
        check("issue_not_busy", 32'(busy), 32'd0);
        if (rx < n_exp) check("order", 32'(tx_data), 32'(evec[rx]));
        else            check("extra_issue", 32'(rx), 32'(n_exp));
        rx++;
        tx_ready = 1'b0;
        busy     = busy_len;
      end else if (busy > 0) begin
        busy--;
        if (busy == 0) tx_ready = 1'b1;
      end
    end
    wr_en = 1'b0;
    check("words_received", 32'(rx), 32'(n_exp));
    tx_ready = 1'b0;
    step();
    step();
  endtask

  initial begin
    logic seen;

    // Reset state
    do_reset();
    check("rst_count", 32'(count), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_tx_send", 32'(tx_send), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    check("rst_state", 32'(dut.state_q), 32'(IDLE));

    // Single word latency: strobe at push+3 for exactly one cycle
    tx_ready = 1'b1;
    push_word(9'h1A5);
    check("lat_t1", 32'(tx_send), 32'd0);
    step();
    check("lat_t2", 32'(tx_send), 32'd0);
    step();
    check("lat_t3_send", 32'(tx_send), 32'd1);
    check("lat_t3_data", 32'(tx_data), 32'h1A5);
    check("lat_count", 32'(count), 32'd0);
    check("lat_empty", 32'(empty), 32'd1);
    step();
    check("lat_t4", 32'(tx_send), 32'd0);
    check("lat_hold_data", 32'(tx_data), 32'h1A5);
    tx_ready = 1'b0;
    step();

    // Fill, overflow, set-beats-clear, clear
    do_reset();
    for (int i = 1; i <= 8; i++) push_word(WIDTH'(i));
    check("fill_full", 32'(full), 32'd1);
    check("fill_count", 32'(count), 32'd8);
    push_word(9'h0FF);
    check("ovf_set", 32'(overflow), 32'd1);
    check("ovf_count", 32'(count), 32'd8);
    clr_overflow = 1'b1;
    push_word(9'h0FE);
    check("ovf_set_wins", 32'(overflow), 32'd1);
    step();
    clr_overflow = 1'b0;
    check("ovf_cleared", 32'(overflow), 32'd0);

    // Push while full, pop same cycle: push still dropped
    tx_ready = 1'b1;
    step();
    push_word(9'h0EE);
    check("full_pop_count", 32'(count), 32'd7);
    check("full_pop_send", 32'(tx_send), 32'd1);
    check("full_pop_data", 32'(tx_data), 32'h001);
    check("full_pop_ovf", 32'(overflow), 32'd1);
    tx_ready = 1'b0;
    step();
    step();
    for (int i = 0; i < 7; i++) evec[i] = WIDTH'(i + 2);
    tx_ready = 1'b1;
    run_model(0, 7, 4, 500);

    // Three words through a slow transmitter
    do_reset();
    for (int i = 0; i < 3; i++) begin
      pvec[i] = WIDTH'(i + 1);
      evec[i] = WIDTH'(i + 1);
    end
    tx_ready = 1'b1;
    run_model(3, 3, 100, 1000);

    // Single-cycle ready pulse is rejected
    do_reset();
    push_word(9'h055);
    tx_ready = 1'b1;
    step();
    check("pulse_arm", 32'(dut.state_q), 32'(ARM));
    tx_ready = 1'b0;
    step();
    check("pulse_idle", 32'(dut.state_q), 32'(IDLE));
    seen = tx_send;
    for (int i = 0; i < 4; i++) begin
      step();
      seen = seen | tx_send;
    end
    check("pulse_no_send", 32'(seen), 32'd0);
    check("pulse_count", 32'(count), 32'd1);

    // Simultaneous push and pop at count=4
    do_reset();
    for (int i = 0; i < 4; i++) push_word(WIDTH'(9'h040 + i));
    tx_ready = 1'b1;
    step();
    push_word(9'h0AA);
    check("pp_count", 32'(count), 32'd4);
    check("pp_send", 32'(tx_send), 32'd1);
    check("pp_data", 32'(tx_data), 32'h040);
    tx_ready = 1'b0;
    step();
    step();
    evec[0] = 9'h041;
    evec[1] = 9'h042;
    evec[2] = 9'h043;
    evec[3] = 9'h0AA;
    tx_ready = 1'b1;
    run_model(0, 4, 3, 500);

    // Pointer wrap over 20 words
    do_reset();
    for (int i = 0; i < 20; i++) begin
      pvec[i] = WIDTH'(9'h100 + i * 13);
      evec[i] = WIDTH'(9'h100 + i * 13);
    end
    tx_ready = 1'b1;
    run_model(20, 20, 3, 3000);

    // Reset during SEND with 5 words queued
    do_reset();
    for (int i = 0; i < 6; i++) push_word(WIDTH'(9'h1F0 + i));
    tx_ready = 1'b1;
    step();
    step();
    check("mid_send", 32'(tx_send), 32'd1);
    check("mid_count", 32'(count), 32'd5);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("mid_rst_count", 32'(count), 32'd0);
    check("mid_rst_empty", 32'(empty), 32'd1);
    check("mid_rst_send", 32'(tx_send), 32'd0);
    check("mid_rst_data", 32'(tx_data), 32'd0);
    check("mid_rst_state", 32'(dut.state_q), 32'(IDLE));
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      seen = seen | tx_send;
    end
    check("mid_rst_no_send", 32'(seen), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
